// File: rtl/wf_rgb_pkg.sv
// Shared scan-word layout, pixel-write FSM states and row-select decode
// used by both the RGB scan driver and its receive-side checker.
package wf_rgb_pkg;

  localparam int SCAN_BITS = 32;
  localparam int GRN_LSB   = 24;
  localparam int RED_LSB   = 16;
  localparam int BLU_LSB   = 8;
  localparam int ROW_LSB   = 0;
  localparam int CNT_W     = 6;
  localparam int CNT_SAT   = 33;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } wr_state_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] idx;
  } row_sel_t;

  // Row select is one-cold: exactly one low bit names the row.
  function automatic row_sel_t row_decode(input logic [7:0] sel);
    row_sel_t r;
    r.ok  = 1'b1;
    r.idx = 3'd0;
    case (sel)
      8'hFE:   r.idx = 3'd0;
      8'hFD:   r.idx = 3'd1;
      8'hFB:   r.idx = 3'd2;
      8'hF7:   r.idx = 3'd3;
      8'hEF:   r.idx = 3'd4;
      8'hDF:   r.idx = 3'd5;
      8'hBF:   r.idx = 3'd6;
      8'h7F:   r.idx = 3'd7;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wf_sync_edge.sv
// Multi-stage input synchronizer with a history flop for
// rising/falling edge detection.
module wf_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {STAGES{RST_VAL}};
      hist <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      hist <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~hist;
  assign fall = ~q & hist;

endmodule

// File: rtl/wf_rgb_scan_rx.sv
// Serial RGB scan receiver: rebuilds 32-bit scan words from SCLK/SDIN/SLOAD
// and replays each committed word as eight pixel writes into a mirror RAM.
module wf_rgb_scan_rx
  import wf_rgb_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCLK,
  input  logic       SDIN,
  input  logic       SLOAD,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [2:0] wr_data,
  output logic       busy,
  output logic       row_done,
  output logic       frame_done,
  output logic       err_len,
  output logic       err_row,
  output logic       err_ovr
);

  logic sclk_q, sclk_rise, sclk_fall;
  logic sload_q, sload_rise, sload_fall;
  logic [SYNC_STAGES-1:0] sdin_sync;
  logic sdin_q;
  logic unused_sync;

  wf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .reset(reset), .d(SCLK),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  wf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sload (
    .clk(clk), .reset(reset), .d(SLOAD),
    .q(sload_q), .rise(sload_rise), .fall(sload_fall)
  );

  assign unused_sync = sclk_q ^ sclk_fall;

  // No history flop for data, so it lines up with the SCLK edge detect.
  always_ff @(posedge clk) begin
    if (reset) sdin_sync <= '0;
    else       sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], SDIN};
  end

  assign sdin_q = sdin_sync[SYNC_STAGES-1];

  logic [SCAN_BITS-1:0]       shreg;
  logic [CNT_W-1:0]           bit_cnt;
  logic [SCAN_BITS-1:BLU_LSB] pix_q;
  logic [2:0]                 row_q;
  logic [2:0]                 col;
  wr_state_t                  state;
  row_sel_t                   rsel;
  logic                       commit;

  assign rsel   = row_decode(shreg[ROW_LSB +: 8]);
  assign commit = sload_rise && (bit_cnt != '0);

  function automatic logic [2:0] pixel(
    input logic [SCAN_BITS-1:BLU_LSB] w,
    input logic [2:0]                 c
  );
    return {w[RED_LSB + int'(c)],
            w[GRN_LSB + int'(c)],
            w[BLU_LSB + int'(c)]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      pix_q      <= '0;
      row_q      <= '0;
      col        <= '0;
      state      <= ST_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      err_row    <= 1'b0;
      err_ovr    <= 1'b0;
    end else begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      err_len    <= 1'b0;
      err_row    <= 1'b0;
      err_ovr    <= 1'b0;

      if (sload_rise || sload_fall) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (sclk_rise && !sload_q) begin
        shreg <= {shreg[SCAN_BITS-2:0], sdin_q};
        if (bit_cnt != CNT_W'(CNT_SAT))
          bit_cnt <= bit_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          wr_en <= 1'b0;
          busy  <= 1'b0;
          if (commit) begin
            if (bit_cnt != CNT_W'(SCAN_BITS)) begin
              err_len <= 1'b1;
            end else if (!rsel.ok) begin
              err_row <= 1'b1;
            end else begin
              state   <= ST_WRITE;
              pix_q   <= shreg[SCAN_BITS-1:BLU_LSB];
              row_q   <= rsel.idx;
              col     <= 3'd0;
              wr_en   <= 1'b1;
              busy    <= 1'b1;
              wr_addr <= {rsel.idx, 3'd0};
              wr_data <= pixel(shreg[SCAN_BITS-1:BLU_LSB], 3'd0);
            end
          end
        end
        ST_WRITE: begin
          if (commit) err_ovr <= 1'b1;
          if (col == 3'd7) begin
            state <= ST_IDLE;
            wr_en <= 1'b0;
            busy  <= 1'b0;
          end else begin
            col        <= col + 3'd1;
            wr_addr    <= {row_q, col + 3'd1};
            wr_data    <= pixel(pix_q, col + 3'd1);
            row_done   <= (col == 3'd6);
            frame_done <= (col == 3'd6) && (row_q == 3'd7);
          end
        end
      endcase
    end
  end

endmodule
